// File: rtl/wbuserializer.sv
// Codeword-to-printable-byte serializer with FIFO, line wrap,
// idle keep-alive and one-shot interrupt marker.
module wbuserializer #(
    parameter int         CW          = 36,
    parameter int         LGFIFO      = 4,
    parameter int         LINELEN     = 64,
    parameter int         IDLE_CYCLES = 1000,
    parameter logic [7:0] IDLE_CHAR   = 8'h2E,
    parameter logic [7:0] INT_CHAR    = 8'h21
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stb,
    input  logic [CW-1:0]     i_codword,
    input  logic              i_bus_busy,
    input  logic              i_int,
    output logic              o_stb,
    output logic [7:0]        o_char,
    input  logic              i_tx_busy,
    output logic              o_fifo_err,
    output logic [LGFIFO:0]   o_fifo_fill
);
    localparam int NCH   = CW / 6;
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int FW    = LGFIFO + 1;
    localparam int IW    = $clog2(IDLE_CYCLES);
    localparam logic [KW-1:0] K_LAST   = KW'(NCH - 1);
    localparam logic [IW-1:0] I_LAST   = IW'(IDLE_CYCLES - 1);
    localparam logic [7:0]    COL_WRAP = 8'(LINELEN);
    localparam logic [7:0]    NL       = 8'h0A;

    typedef enum logic {BOUNDARY, WORD} state_t;

    function automatic logic [7:0] enc(input logic [5:0] s);
        logic [7:0] v;
        v = {2'b00, s};
        unique case (1'b1)
            (s < 6'd10):                enc = v + 8'h30;
            (s >= 6'd10 && s < 6'd36):  enc = v + 8'h37;
            (s >= 6'd36 && s < 6'd62):  enc = v + 8'h3D;
            (s == 6'd62):               enc = 8'h40;
            default:                    enc = 8'h25;
        endcase
    endfunction

    logic [CW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   fill;
    state_t            state;
    logic [KW-1:0]     k;
    logic [CW-1:0]     sreg;
    logic [7:0]        col, col_nx;
    logic [IW-1:0]     idle_cnt;
    logic              int_q, int_pending, cur_nl, cur_int;
    logic              go, accept, last, pend, int_rise;
    logic              fifo_empty, fifo_full, rd_en, wr_en;
    logic              idle_ok, idle_to;
    logic [CW-1:0]     rd_data;

    assign o_fifo_fill = fill;

    // "last" marks the cycle where a boundary decision may be taken
    always_comb begin
        go         = !i_tx_busy;
        accept     = o_stb && go;
        last       = (state == BOUNDARY) || (k == K_LAST);
        fifo_empty = (fill == '0);
        fifo_full  = (fill == FW'(DEPTH));
        int_rise   = i_int && !int_q;
        pend       = int_pending && !(accept && cur_int);
        col_nx     = col;
        if (accept)
            col_nx = cur_nl ? 8'd0 : ((col == 8'hFF) ? col : col + 8'd1);
        rd_data    = mem[rd_ptr];
        rd_en      = go && last && !pend && (col_nx < COL_WRAP) && !fifo_empty;
        wr_en      = i_stb && (!fifo_full || rd_en);
        idle_ok    = go && fifo_empty && (state == BOUNDARY) && !o_stb
                     && !i_bus_busy && !i_stb;
        idle_to    = idle_ok && (idle_cnt == I_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= i_codword;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            o_fifo_err  <= 1'b0;
            int_q       <= 1'b0;
            int_pending <= 1'b0;
            col         <= '0;
            idle_cnt    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + LGFIFO'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + LGFIFO'(1);
            fill        <= fill + FW'(wr_en) - FW'(rd_en);
            o_fifo_err  <= i_stb && !wr_en;
            int_q       <= i_int;
            int_pending <= pend || int_rise;
            col         <= col_nx;
            if (accept || i_bus_busy || i_stb)
                idle_cnt <= '0;
            else if (idle_ok)
                idle_cnt <= idle_to ? '0 : idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= BOUNDARY;
            k       <= '0;
            sreg    <= '0;
            o_stb   <= 1'b0;
            o_char  <= '0;
            cur_nl  <= 1'b0;
            cur_int <= 1'b0;
        end else if (go) begin
            cur_nl  <= 1'b0;
            cur_int <= 1'b0;
            if (!last) begin
                o_stb  <= 1'b1;
                o_char <= enc(sreg[CW-1 -: 6]);
                sreg   <= sreg << 6;
                k      <= k + KW'(1);
            end else if (pend) begin
                state   <= BOUNDARY;
                o_stb   <= 1'b1;
                o_char  <= INT_CHAR;
                cur_int <= 1'b1;
            end else if (col_nx >= COL_WRAP) begin
                state  <= BOUNDARY;
                o_stb  <= 1'b1;
                o_char <= NL;
                cur_nl <= 1'b1;
            end else if (!fifo_empty) begin
                state  <= WORD;
                k      <= '0;
                o_stb  <= 1'b1;
                o_char <= enc(rd_data[CW-1 -: 6]);
                sreg   <= rd_data << 6;
            end else if (idle_to) begin
                state  <= BOUNDARY;
                o_stb  <= 1'b1;
                o_char <= (col_nx != 8'd0) ? NL : IDLE_CHAR;
                cur_nl <= (col_nx != 8'd0);
            end else begin
                state <= BOUNDARY;
                o_stb <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wbuserializer.sv
// Scoreboard bench for wbuserializer: expected bytes queued at stimulus,
// popped by a monitor on each accepted output byte.
module tb_wbuserializer;
    localparam int CW      = 36;
    localparam int LGFIFO  = 2;
    localparam int LINELEN = 12;
    localparam int IDLE    = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_stb;
    logic [CW-1:0]     codword;
    logic              bus_busy;
    logic              i_int;
    logic              tx_busy;
    logic              o_stb;
    logic [7:0]        o_char;
    logic              fifo_err;
    logic [LGFIFO:0]   fill;

    int                checks = 0;
    int                failures = 0;
    logic [7:0]        exp_q[$];

    wbuserializer #(
        .CW(CW), .LGFIFO(LGFIFO), .LINELEN(LINELEN), .IDLE_CYCLES(IDLE),
        .IDLE_CHAR(8'h2E), .INT_CHAR(8'h21)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb(i_stb), .i_codword(codword),
        .i_bus_busy(bus_busy), .i_int(i_int), .o_stb(o_stb),
        .o_char(o_char), .i_tx_busy(tx_busy), .o_fifo_err(fifo_err),
        .o_fifo_fill(fill)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        logic       hold;
        logic [7:0] hold_char;
        logic [7:0] e;
        hold = 1'b0;
        hold_char = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (o_stb !== 1'b1 || o_char !== hold_char) begin
                        failures++;
                        $display("FAIL stall_hold got stb=%b char=%h required stb=1 char=%h",
                                 o_stb, o_char, hold_char);
                    end
                end
                if (o_stb && !tx_busy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte got=%h required none", o_char);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_char !== e) begin
                            failures++;
                            $display("FAIL out_byte got=%h required=%h", o_char, e);
                        end
                    end
                end
                hold = o_stb && tx_busy;
                hold_char = o_char;
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back(s[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_stb = 1'b0;
        codword = '0;
        tx_busy = 1'b0;
        i_int = 1'b0;
        bus_busy = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [CW-1:0] w);
        i_stb = 1'b1;
        codword = w;
        @(posedge clk);
        #1 i_stb = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b1;
        i_stb = 1'b0;
        codword = '0;
        tx_busy = 1'b0;
        bus_busy = 1'b1;
        i_int = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL reset_stb got=%b required=0", o_stb);
        end
        if (o_char !== 8'h00) begin
            failures++; $display("FAIL reset_char got=%h required=00", o_char);
        end
        if (fifo_err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b required=0", fifo_err);
        end
        if (fill !== '0) begin
            failures++; $display("FAIL reset_fill got=%0d required=0", fill);
        end
        repeat (2) @(posedge clk);
        push_str("!");
        #1 rst_n = 1'b1;
        drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL reset_int_marker got=%0d pending required=0", exp_q.size());
        end
        i_int = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        push_str("4ZHMU9");
        strobe(36'h123456789);
        checks += 2;
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL basic_lat1_stb got=%b required=0", o_stb);
        end
        if (fill !== 3'd1) begin
            failures++; $display("FAIL basic_fill1 got=%0d required=1", fill);
        end
        @(posedge clk);
        #1;
        checks += 3;
        if (o_stb !== 1'b1) begin
            failures++; $display("FAIL basic_lat2_stb got=%b required=1", o_stb);
        end
        if (o_char !== 8'h34) begin
            failures++; $display("FAIL basic_first got=%h required=34", o_char);
        end
        if (fill !== 3'd0) begin
            failures++; $display("FAIL basic_fill0 got=%0d required=0", fill);
        end
        drain(30, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL basic_drain got=%0d pending required=0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_encoding();
        bit ok;
        do_reset();
        push_str("000000%%%%%%\n@@@@@@");
        strobe(36'h000000000);
        strobe(36'hFFFFFFFFF);
        strobe(36'hFBEFBEFBE);
        drain(100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL encoding_drain got=%0d pending required=0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        push_str("4ZHMU9@@@@@@\n");
        strobe(36'h123456789);
        strobe(36'hFBEFBEFBE);
        while (exp_q.size() != 0 && n < 300) begin
            tx_busy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 n++;
        end
        tx_busy = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL stall_drain got=%0d pending required=0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [CW-1:0] words [6];
        logic          exp_err;
        logic [LGFIFO:0] exp_fill;
        words[0] = 36'h123456789;
        words[1] = 36'h000000000;
        words[2] = 36'hFFFFFFFFF;
        words[3] = 36'hFBEFBEFBE;
        words[4] = 36'h000000000;
        words[5] = 36'hFFFFFFFFF;
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_stb = 1'b1;
            codword = words[i];
            @(posedge clk);
            #1;
            exp_err = (i >= 4);
            exp_fill = (i >= 3) ? 3'd4 : 3'(i + 1);
            checks += 2;
            if (fifo_err !== exp_err) begin
                failures++;
                $display("FAIL ovf_err strobe=%0d got=%b required=%b", i + 1, fifo_err, exp_err);
            end
            if (fill !== exp_fill) begin
                failures++;
                $display("FAIL ovf_fill strobe=%0d got=%0d required=%0d", i + 1, fill, exp_fill);
            end
        end
        i_stb = 1'b0;
        @(posedge clk);
        #1;
        checks += 3;
        if (fifo_err !== 1'b0) begin
            failures++; $display("FAIL ovf_err_pulse got=%b required=0", fifo_err);
        end
        if (fill !== 3'd4) begin
            failures++; $display("FAIL ovf_fill_hold got=%0d required=4", fill);
        end
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL ovf_busy_stb got=%b required=0", o_stb);
        end
        push_str("4ZHMU9000000\n%%%%%%@@@@@@\n");
        tx_busy = 1'b0;
        drain(100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL ovf_drain got=%0d pending required=0", exp_q.size());
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_line_wrap();
        bit ok;
        int n1 = 0;
        int n2 = 0;
        do_reset();
        push_str("000000000000\n000000");
        strobe(36'h0);
        strobe(36'h0);
        strobe(36'h0);
        drain(100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_drain got=%0d pending required=0", exp_q.size());
        end
        push_str("\n.");
        bus_busy = 1'b0;
        do begin
            @(posedge clk);
            #1 n1++;
        end while (!o_stb && n1 < 3 * IDLE);
        checks++;
        if (n1 != IDLE) begin
            failures++; $display("FAIL idle_newline_delay got=%0d required=%0d", n1, IDLE);
        end
        do begin
            @(posedge clk);
            #1 n2++;
        end while (!o_stb && n2 < 3 * IDLE);
        checks++;
        if (n2 != IDLE + 1) begin
            failures++; $display("FAIL idle_char_delay got=%0d required=%0d", n2, IDLE + 1);
        end
        bus_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL idle_drain got=%0d pending required=0", exp_q.size());
        end
    endtask

    task automatic test_interrupt();
        bit ok;
        do_reset();
        push_str("4ZHMU9!000000\n");
        strobe(36'h123456789);
        strobe(36'h0);
        repeat (2) @(posedge clk);
        #1 i_int = 1'b1;
        drain(60, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL int_order got=%0d pending required=0", exp_q.size());
        end
        i_int = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_reset();
        push_str("4ZHMU9!");
        strobe(36'h123456789);
        @(posedge clk);
        #1 i_int = 1'b1;
        @(posedge clk);
        #1 i_int = 1'b0;
        @(posedge clk);
        #1 i_int = 1'b1;
        @(posedge clk);
        #1 i_int = 1'b0;
        drain(40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL int_collapse got=%0d pending required=0", exp_q.size());
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL int_single got=%b required=0", o_stb);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        push_str("4ZH");
        strobe(36'h123456789);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL midword_prefix got=%0d pending required=0", exp_q.size());
        end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL midword_stb got=%b required=0", o_stb);
        end
        if (fill !== '0) begin
            failures++; $display("FAIL midword_fill got=%0d required=0", fill);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (o_stb !== 1'b0) begin
            failures++; $display("FAIL midword_quiet got=%b required=0", o_stb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_encoding();
        test_back_to_back();
        test_overflow();
        test_line_wrap();
        test_interrupt();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
